xadc_scan_avg: RTL and testbench

Parametrised multi-channel XADC scanner and averager sitting between the `xadc_wiz_0` DRP port and the display/LED logic. It walks a configurable list of DRP channel addresses, issues one DRP read per end-of-conversion, averages 2^AVG_LOG2 samples per channel and flags over-range readings. Every FRAME_CYCLES it snapshots all channel averages into a display bank, so downstream consumers (bin2dec, LED bar) see stable per-frame values.

---
 rtl/xadc_scan_avg.sv | 214 +++++++++++++++++++++
 tb/tb_xadc_scan_avg.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_scan_avg.sv
// -----------------------------------------------------------------------------
// xadc_scan_avg
//
// Multi-channel XADC scanner and averager. It sits between the xadc_wiz_0 DRP
// port and the display logic. Each end-of-conversion triggers one DRP read of
// the current channel. 2^AVG_LOG2 samples are summed per channel, and the
// truncated average is written to a live bank. Every FRAME_CYCLES clocks the
// live bank is copied into a display bank, so downstream logic sees values
// that stay stable for a whole frame.
//
// Ports:
//   CLK100MHZ     in   system clock, also the DRP dclk
//   reset         in   asynchronous active-high reset
//   eoc           in   XADC end-of-conversion pulse
//   daddr         out  DRP address of the current channel (registered)
//   den           out  DRP enable, one-cycle pulse per read
//   drdy          in   DRP data ready
//   do_in         in   DRP read data
//   sel           in   display channel select
//   sel_data      out  snapshot average of channel sel (1-clock latency)
//   sel_ovr       out  snapshot over-range flag of channel sel
//   result_valid  out  one-cycle pulse when a live average completes
//   result_ch     out  channel of the completed average
//   result_data   out  completed live average
//   frame_tick    out  one-cycle pulse when the display snapshot is taken
//   drp_err       out  sticky DRP timeout flag, cleared only by reset
//   state_dbg     out  current FSM state (S_WAIT_EOC=0, S_READ=1, S_ACCUM=2)
//
// DRP handshake: den is a request that is high for exactly one cycle. The
// read completes on the first cycle drdy is sampled high while the FSM is in
// S_READ. drdy seen in any other state, and eoc seen outside S_WAIT_EOC, are
// dropped. If drdy does not arrive within DRP_TIMEOUT cycles (the den cycle
// is cycle 1), the read is abandoned.
// -----------------------------------------------------------------------------
module xadc_scan_avg #(
    parameter int                  NUM_CH       = 4,
    parameter logic [7*NUM_CH-1:0] CH_ADDR      = {7'h1f, 7'h17, 7'h1e, 7'h16},
    parameter int                  AVG_LOG2     = 2,
    parameter logic [15:0]         OVR_THRESH   = 16'hFFD0,
    parameter int                  FRAME_CYCLES = 10000000,
    parameter int                  DRP_TIMEOUT  = 255,
    localparam int                 CW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic          CLK100MHZ,
    input  logic          reset,
    input  logic          eoc,
    output logic [6:0]    daddr,
    output logic          den,
    input  logic          drdy,
    input  logic [15:0]   do_in,
    input  logic [CW-1:0] sel,
    output logic [15:0]   sel_data,
    output logic          sel_ovr,
    output logic          result_valid,
    output logic [CW-1:0] result_ch,
    output logic [15:0]   result_data,
    output logic          frame_tick,
    output logic          drp_err,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_WAIT_EOC = 2'd0,
        S_READ     = 2'd1,
        S_ACCUM    = 2'd2
    } state_t;

    localparam int AW = 16 + AVG_LOG2;                      // accumulator width
    localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;      // sample counter width
    localparam int WW = $clog2(DRP_TIMEOUT + 1);            // wait counter width
    localparam int FW = $clog2(FRAME_CYCLES);               // frame counter width
    localparam int NB = 1 << CW;                            // bank depth (power of two so sel indexes safely)

    localparam logic [SW-1:0] LAST_SMP   = SW'((1 << AVG_LOG2) - 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(DRP_TIMEOUT);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0] CH_LAST    = CW'(NUM_CH - 1);

    state_t          state;
    logic [CW-1:0]   ch;
    logic [AW-1:0]   acc;
    logic            ovr_acc;
    logic [SW-1:0]   smp_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [FW-1:0]   frame_cnt;

    logic [15:0]     live_bank [NB];
    logic [NB-1:0]   live_ovr;
    logic [15:0]     disp_bank [NB];
    logic [NB-1:0]   disp_ovr;

    logic [AW-1:0]   acc_sum;
    logic [15:0]     avg_now;
    logic            smp_ovr;
    logic            last_smp;
    logic            complete_now;
    logic [CW-1:0]   ch_next;

    assign acc_sum      = acc + AW'(do_in);
    assign avg_now      = acc_sum[AW-1:AVG_LOG2];           // truncating divide by 2^AVG_LOG2
    assign smp_ovr      = (do_in > OVR_THRESH);
    assign last_smp     = (smp_cnt == LAST_SMP);
    assign complete_now = (state == S_READ) && drdy && last_smp;
    assign ch_next      = (ch == CH_LAST) ? '0 : ch + CW'(1);
    assign state_dbg    = state;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state        <= S_WAIT_EOC;
            ch           <= '0;
            acc          <= '0;
            ovr_acc      <= 1'b0;
            smp_cnt      <= '0;
            wait_cnt     <= '0;
            frame_cnt    <= '0;
            daddr        <= CH_ADDR[6:0];
            den          <= 1'b0;
            result_valid <= 1'b0;
            result_ch    <= '0;
            result_data  <= '0;
            frame_tick   <= 1'b0;
            drp_err      <= 1'b0;
            sel_data     <= '0;
            sel_ovr      <= 1'b0;
            live_ovr     <= '0;
            disp_ovr     <= '0;
            for (int i = 0; i < NB; i++) begin
                live_bank[i] <= '0;
                disp_bank[i] <= '0;
            end
        end else begin
            den          <= 1'b0;
            result_valid <= 1'b0;

            case (state)
                S_WAIT_EOC: begin
                    if (eoc) begin
                        state    <= S_READ;
                        den      <= 1'b1;
                        wait_cnt <= WW'(1);         // the den cycle counts as cycle 1
                    end
                end

                S_READ: begin
                    if (drdy) begin
                        // The add is committed on the edge into S_ACCUM so the
                        // new accumulator and any completed result are visible
                        // together during the S_ACCUM cycle.
                        state <= S_ACCUM;
                        if (last_smp) begin
                            live_bank[ch] <= avg_now;
                            live_ovr[ch]  <= ovr_acc | smp_ovr;
                            result_valid  <= 1'b1;
                            result_ch     <= ch;
                            result_data   <= avg_now;
                            acc           <= '0;
                            ovr_acc       <= 1'b0;
                            smp_cnt       <= '0;
                            ch            <= ch_next;
                            daddr         <= CH_ADDR[7*ch_next +: 7];
                        end else begin
                            acc     <= acc_sum;
                            ovr_acc <= ovr_acc | smp_ovr;
                            smp_cnt <= smp_cnt + SW'(1);
                        end
                    end else if (wait_cnt == WAIT_MAX) begin
                        // Abandon the read: drop the partial block of this
                        // channel, keep its live entry, move on.
                        state   <= S_WAIT_EOC;
                        drp_err <= 1'b1;
                        acc     <= '0;
                        ovr_acc <= 1'b0;
                        smp_cnt <= '0;
                        ch      <= ch_next;
                        daddr   <= CH_ADDR[7*ch_next +: 7];
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end

                S_ACCUM: begin
                    state <= S_WAIT_EOC;
                end

                default: begin
                    state <= S_WAIT_EOC;
                end
            endcase

            // Free-running frame counter. A channel completing on the snapshot
            // edge is forwarded so the snapshot carries the new value.
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt  <= '0;
                frame_tick <= 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (complete_now && (ch == CW'(i))) begin
                        disp_bank[i] <= avg_now;
                        disp_ovr[i]  <= ovr_acc | smp_ovr;
                    end else begin
                        disp_bank[i] <= live_bank[i];
                        disp_ovr[i]  <= live_ovr[i];
                    end
                end
            end else begin
                frame_cnt  <= frame_cnt + FW'(1);
                frame_tick <= 1'b0;
            end

            sel_data <= disp_bank[sel];
            sel_ovr  <= disp_ovr[sel];
        end
    end

endmodule

// File: tb/tb_xadc_scan_avg.sv
// -----------------------------------------------------------------------------
// tb_xadc_scan_avg
//
// Bench for xadc_scan_avg with NUM_CH=4, AVG_LOG2=2, FRAME_CYCLES=100,
// DRP_TIMEOUT=8. A table of per-channel sample blocks with hand-computed
// averages drives the DRP model. The expected {channel, average} is queued
// when the last sample of a block is driven and is compared when result_valid
// appears. Hand-written sequences cover the snapshot timing, the snapshot
// that coincides with a completion, the DRP timeout and an asynchronous reset
// in the middle of a read.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xadc_scan_avg;

    localparam int NUM_CH       = 4;
    localparam int AVG_LOG2     = 2;
    localparam int FRAME_CYCLES = 100;
    localparam int DRP_TIMEOUT  = 8;
    localparam int W            = 18;   // scoreboard entry: {ch, average}

    typedef struct packed {
        logic [1:0]       ch;
        logic [3:0][15:0] s;
        logic [15:0]      avg;
        logic             ovr;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        eoc = 1'b0;
    logic        drdy = 1'b0;
    logic [15:0] do_in = '0;
    logic [1:0]  sel = '0;

    logic [6:0]  daddr;
    logic        den;
    logic [15:0] sel_data;
    logic        sel_ovr;
    logic        result_valid;
    logic [1:0]  result_ch;
    logic [15:0] result_data;
    logic        frame_tick;
    logic        drp_err;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_ch = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    logic [6:0]   addr_tab [4];
    vec_t         vtab [13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xadc_scan_avg #(
        .NUM_CH      (NUM_CH),
        .CH_ADDR     ({7'h1f, 7'h17, 7'h1e, 7'h16}),
        .AVG_LOG2    (AVG_LOG2),
        .OVR_THRESH  (16'hFFD0),
        .FRAME_CYCLES(FRAME_CYCLES),
        .DRP_TIMEOUT (DRP_TIMEOUT)
    ) dut (
        .CLK100MHZ   (clk),
        .reset       (reset),
        .eoc         (eoc),
        .daddr       (daddr),
        .den         (den),
        .drdy        (drdy),
        .do_in       (do_in),
        .sel         (sel),
        .sel_data    (sel_data),
        .sel_ovr     (sel_ovr),
        .result_valid(result_valid),
        .result_ch   (result_ch),
        .result_data (result_data),
        .frame_tick  (frame_tick),
        .drp_err     (drp_err),
        .state_dbg   (state_dbg)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkvec(input logic [1:0] ch, input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] c, input logic [15:0] d,
                                   input logic [15:0] avg, input logic ovr);
        vec_t v;
        v.ch   = ch;
        v.s[0] = a;
        v.s[1] = b;
        v.s[2] = c;
        v.s[3] = d;
        v.avg  = avg;
        v.ovr  = ovr;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: ch %0d data %h, none expected (t=%0t)",
                         result_ch, result_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result", {14'd0, result_ch, result_data}, {14'd0, mon_exp});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issue one eoc and act as the DRP slave. Called at a negedge in S_WAIT_EOC.
    // With respond=0 it returns in the second S_READ cycle without drdy.
    task automatic drp_read(input logic [15:0] data, input int delay, input bit respond);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        eoc = 1'b1;
        @(negedge clk);
        eoc = 1'b0;
        chk("den_pulse", den, 1);
        chk("daddr", daddr, addr_tab[exp_ch]);
        @(negedge clk);
        chk("den_low", den, 0);
        if (respond) begin
            repeat (delay - 1) @(negedge clk);
            drdy  = 1'b1;
            do_in = data;
            @(negedge clk);
            drdy  = 1'b0;
            do_in = 16'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input int i);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back({vtab[i].ch, vtab[i].avg});
            drp_read(vtab[i].s[k], $urandom_range(1, 3), 1'b1);
        end
        exp_ch = (exp_ch + 1) % NUM_CH;
    endtask

    // Wait (bounded) for frame_tick; counts sel_data changes not preceded by a tick.
    task automatic wait_tick(output int tick_cyc, output int changes);
        logic [15:0] prev_sd;
        logic        prev_tick;
        bit          found;
        prev_sd   = sel_data;
        prev_tick = frame_tick;
        found     = 1'b0;
        changes   = 0;
        tick_cyc  = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (sel_data !== prev_sd && !prev_tick) changes++;
            prev_sd   = sel_data;
            prev_tick = frame_tick;
            if (frame_tick) begin
                found    = 1'b1;
                tick_cyc = cyc;
            end
        end
        chk("frame_tick_seen", found, 1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        int t1, t2, chg;

        addr_tab = '{7'h16, 7'h1e, 7'h17, 7'h1f};
        vtab[0]  = mkvec(2'd0, 16'h1000, 16'h1004, 16'h1008, 16'h100C, 16'h1006, 1'b0);
        vtab[1]  = mkvec(2'd1, 16'h0001, 16'h0002, 16'h0003, 16'h0005, 16'h0002, 1'b0);
        vtab[2]  = mkvec(2'd2, 16'hFFD0, 16'hFFD1, 16'h0000, 16'h0000, 16'h7FE8, 1'b1);
        vtab[3]  = mkvec(2'd3, 16'hFFD0, 16'hFFD0, 16'hFFD0, 16'hFFD0, 16'hFFD0, 1'b0);
        vtab[4]  = mkvec(2'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        vtab[5]  = mkvec(2'd1, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
        vtab[6]  = mkvec(2'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        vtab[7]  = mkvec(2'd3, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        vtab[8]  = mkvec(2'd2, 16'h0004, 16'h0004, 16'h0004, 16'h0004, 16'h0004, 1'b0);
        vtab[9]  = mkvec(2'd3, 16'hFFD1, 16'h0000, 16'h0000, 16'h0000, 16'h3FF4, 1'b1);
        vtab[10] = mkvec(2'd0, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 1'b0);
        vtab[11] = mkvec(2'd1, 16'h0008, 16'h0008, 16'h0008, 16'h0008, 16'h0008, 1'b0);
        vtab[12] = mkvec(2'd0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280, 1'b0);

        // reset state
        reset = 1'b1;
        sel   = 2'd1;
        repeat (3) @(negedge clk);
        chk("rst_daddr", daddr, 7'h16);
        chk("rst_den", den, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_data", result_data, 0);
        chk("rst_frame_tick", frame_tick, 0);
        chk("rst_drp_err", drp_err, 0);
        chk("rst_sel_data", sel_data, 0);
        chk("rst_state", state_dbg, 0);
        reset = 1'b0;

        // first pass over all channels
        for (int i = 0; i < 4; i++) run_vec(i);

        // snapshot: appears one clock after frame_tick, sel latency one clock
        wait_tick(t1, chg);
        @(negedge clk);
        chk("snap_frame_tick_pulse", frame_tick, 0);
        chk("snap_ch1_data", sel_data, vtab[1].avg);
        chk("snap_ch1_ovr", sel_ovr, vtab[1].ovr);
        sel = 2'd2;
        @(negedge clk);
        chk("snap_ch2_data", sel_data, vtab[2].avg);
        chk("snap_ch2_ovr", sel_ovr, vtab[2].ovr);
        sel = 2'd3;
        @(negedge clk);
        chk("snap_ch3_data", sel_data, vtab[3].avg);
        chk("snap_ch3_ovr", sel_ovr, vtab[3].ovr);
        sel = 2'd1;
        @(negedge clk);
        wait_tick(t2, chg);
        chk("frame_period", t2 - t1, FRAME_CYCLES);
        chk("sel_data_stable", chg, 0);

        // second pass: wrap-around, saturation, ovr clear, truncation
        for (int i = 4; i < 8; i++) run_vec(i);

        // completion on the snapshot edge: the new value must win
        sel = 2'd0;
        for (int k = 0; k < 3; k++) drp_read(16'h0010, $urandom_range(1, 3), 1'b1);
        wait_tick(t1, chg);
        repeat (FRAME_CYCLES - 4) @(negedge clk);
        exp_q.push_back({2'd0, 16'h0010});
        eoc = 1'b1;
        @(negedge clk);
        eoc = 1'b0;
        chk("corner_den", den, 1);
        @(negedge clk);
        @(negedge clk);
        drdy  = 1'b1;
        do_in = 16'h0010;
        @(negedge clk);
        drdy  = 1'b0;
        chk("corner_frame_tick", frame_tick, 1);
        chk("corner_old_data", sel_data, vtab[4].avg);
        chk("corner_old_ovr", sel_ovr, vtab[4].ovr);
        @(negedge clk);
        chk("corner_new_data", sel_data, 16'h0010);
        chk("corner_new_ovr", sel_ovr, 0);
        exp_ch = 1;
        sel = 2'd1;
        @(negedge clk);
        chk("snap2_ch1_data", sel_data, vtab[5].avg);
        sel = 2'd2;
        @(negedge clk);
        chk("snap2_ch2_data", sel_data, vtab[6].avg);
        chk("snap2_ch2_ovr", sel_ovr, vtab[6].ovr);

        // DRP timeout on channel 1 after a partial block
        drp_read(16'h4000, 2, 1'b1);
        drp_read(16'h4000, 2, 1'b1);
        drp_read(16'h0000, 0, 1'b0);            // returns in timeout cycle 2
        repeat (DRP_TIMEOUT - 2) @(negedge clk);
        chk("timeout_not_early", drp_err, 0);
        @(negedge clk);
        chk("timeout_drp_err", drp_err, 1);
        chk("timeout_daddr", daddr, 7'h17);
        chk("timeout_state", state_dbg, 0);
        exp_ch = 2;
        drdy  = 1'b1;                           // late drdy, must be ignored
        do_in = 16'hFFFF;
        @(negedge clk);
        drdy  = 1'b0;
        @(negedge clk);
        chk("late_drdy_state", state_dbg, 0);
        for (int i = 8; i < 12; i++) run_vec(i);
        chk("drp_err_sticky", drp_err, 1);

        // asynchronous reset in the middle of S_READ
        drp_read(16'h0040, 2, 1'b1);
        drp_read(16'h0040, 2, 1'b1);
        drp_read(16'h0000, 0, 1'b0);
        reset = 1'b1;
        #2;
        chk("areset_daddr", daddr, 7'h16);
        chk("areset_drp_err", drp_err, 0);
        chk("areset_den", den, 0);
        chk("areset_state", state_dbg, 0);
        chk("areset_sel_data", sel_data, 0);
        chk("areset_frame_tick", frame_tick, 0);
        @(negedge clk);
        reset  = 1'b0;
        exp_ch = 0;
        @(negedge clk);
        drdy  = 1'b1;                           // drdy of the aborted read
        do_in = 16'hFFFF;
        @(negedge clk);
        drdy  = 1'b0;
        @(negedge clk);
        chk("post_reset_state", state_dbg, 0);
        run_vec(12);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
